// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares one register-file write port among NREQ requesters. A winner is picked
// round-robin in IDLE. The winner's address and data are registered onto the
// write port for one cycle (WRITE). The FSM then returns to IDLE, so the peak
// rate is one write every two cycles.
//
// Optional feature (macro REGARB_LOCK_EN):
//   Adds a per-requester lock input. A winner that holds lock keeps the port
//   (state LOCKED) and issues back-to-back writes, up to 8 in one burst.
//   Without the macro there is no lock port and only IDLE/WRITE exist.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   req       in   [NREQ]     write request per requester
//   lock      in   [NREQ]     burst lock per requester (REGARB_LOCK_EN only)
//   waddr_in  in   [NREQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   wdata_in  in   [NREQ*DW]  packed data, requester i at [i*DW +: DW]
//   gnt       out  [NREQ]     registered one-hot grant
//   we        out             registered write enable (high iff gnt != 0)
//   waddr     out  [AW]       registered write address (holds when idle)
//   wdata     out  [DW]       registered write data (holds when idle)
//   busy      out             state is not IDLE
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
`ifdef REGARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  input  logic [NREQ*AW-1:0] waddr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]    gnt,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      wdata,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REGARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, WRITE, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              we_nxt;
  logic [AW-1:0]     waddr_nxt;
  logic [DW-1:0]     wdata_nxt;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       sel;
`ifdef REGARB_LOCK_EN
  // Counts writes in the current burst. A value of 0 while LOCKED means the
  // eighth write has been issued (the 3-bit count wrapped), so the burst ends.
  logic [2:0]        cnt, cnt_nxt;
  logic [IW-1:0]     lk_idx, lk_idx_nxt;
`endif

  // Round-robin scan starting at ptr; the extra sel bit absorbs ptr+k before
  // the mod-NREQ fold, so non-power-of-two NREQ wraps correctly.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = {1'b0, ptr} + (IW+1)'(k);
      if (sel >= (IW+1)'(NREQ)) sel = sel - (IW+1)'(NREQ);
      if (!win_found && req[sel[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sel[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    gnt_nxt    = '0;
    we_nxt     = 1'b0;
    waddr_nxt  = waddr;
    wdata_nxt  = wdata;
`ifdef REGARB_LOCK_EN
    cnt_nxt    = cnt;
    lk_idx_nxt = lk_idx;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt[win_idx] = 1'b1;
          we_nxt    = 1'b1;
          waddr_nxt = waddr_in[win_idx*AW +: AW];
          wdata_nxt = wdata_in[win_idx*DW +: DW];
          ptr_nxt   = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          state_nxt = WRITE;
`ifdef REGARB_LOCK_EN
          if (lock[win_idx]) begin
            state_nxt  = LOCKED;
            cnt_nxt    = 3'd1;
            lk_idx_nxt = win_idx;
          end
`endif
        end
      end
      WRITE: state_nxt = IDLE;
`ifdef REGARB_LOCK_EN
      LOCKED: begin
        if (req[lk_idx] && lock[lk_idx] && (cnt != 3'd0)) begin
          gnt_nxt[lk_idx] = 1'b1;
          we_nxt    = 1'b1;
          waddr_nxt = waddr_in[lk_idx*AW +: AW];
          wdata_nxt = wdata_in[lk_idx*DW +: DW];
          cnt_nxt   = cnt + 3'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write port; reset clears it immediately, aborting any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
`ifdef REGARB_LOCK_EN
      cnt    <= 3'd0;
      lk_idx <= '0;
`endif
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      we     <= we_nxt;
      waddr  <= waddr_nxt;
      wdata  <= wdata_nxt;
`ifdef REGARB_LOCK_EN
      cnt    <= cnt_nxt;
      lk_idx <= lk_idx_nxt;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
`ifdef REGARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ*AW-1:0] waddr_in;
  logic [NREQ*DW-1:0] wdata_in;
  logic [NREQ-1:0]    gnt;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               busy;

  typedef struct {
    logic [NREQ-1:0] g;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  regfile_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef REGARB_LOCK_EN
    .lock     (lock),
`endif
    .waddr_in (waddr_in),
    .wdata_in (wdata_in),
    .gnt      (gnt),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr_in[i*AW +: AW] = a;
    wdata_in[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.g = g;
    e.a = a;
    e.d = d;
    sbq.push_back(e);
  endtask

  // Monitor: every cycle the port is active must match the next expected write.
  always @(negedge clk) begin
    if (rst && (we || (gnt != '0))) begin
      check("we_iff_gnt", 32'(we), 32'(gnt != '0));
      if (sbq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: gnt=%b waddr=%0d wdata=0x%h, none expected", gnt, waddr, wdata);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_gnt",   32'(gnt),   32'(mon_e.g));
        check("sb_waddr", 32'(waddr), 32'(mon_e.a));
        check("sb_wdata", 32'(wdata), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    req      = '0;
`ifdef REGARB_LOCK_EN
    lock     = '0;
`endif
    waddr_in = '0;
    wdata_in = '0;
    repeat (2) step();

    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_we",    32'(we),    32'h0);
    check("rst_waddr", 32'(waddr), 32'h0);
    check("rst_wdata", 32'(wdata), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 1'b1;

    // Single request from requester 2
    set_rq(2, 3'd5, 16'hA5C3);
    req = 4'b0100;
    push(4'b0100, 3'd5, 16'hA5C3);
    step();
    check("single_we",   32'(we),   32'h1);
    check("single_busy", 32'(busy), 32'h1);
    req = '0;
    step();
    check("single_we_off",    32'(we),    32'h0);
    check("single_gnt_off",   32'(gnt),   32'h0);
    check("single_busy_off",  32'(busy),  32'h0);
    check("single_hold_addr", 32'(waddr), 32'h5);
    check("single_hold_data", 32'(wdata), 32'hA5C3);

    // Pointer wrap: grant 3, then 1001 goes to 0, ptr becomes 1
    set_rq(3, 3'd6, 16'h3333);
    set_rq(0, 3'd1, 16'h0001);
    req = 4'b1000;
    push(4'b1000, 3'd6, 16'h3333);
    step();
    req = '0;
    step();
    req = 4'b1001;
    push(4'b0001, 3'd1, 16'h0001);
    step();
    req = '0;              // requester 3 withdraws before being sampled
    step();
    repeat (3) begin
      step();
      check("idle_we",   32'(we),   32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end
    set_rq(1, 3'd2, 16'h1111);
    req = 4'b0011;         // ptr is 1, so requester 1 beats 0
    push(4'b0010, 3'd2, 16'h1111);
    step();
    req = '0;
    step();

    // Reset in the middle of a write
    set_rq(2, 3'd7, 16'h2222);
    req = 4'b0100;
    push(4'b0100, 3'd7, 16'h2222);
    step();
    @(negedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    #1;
    check("arst_we",    32'(we),    32'h0);
    check("arst_gnt",   32'(gnt),   32'h0);
    check("arst_busy",  32'(busy),  32'h0);
    check("arst_waddr", 32'(waddr), 32'h0);
    step();
    rst = 1'b1;

    // Round robin from a fresh pointer: 0,1,2,3 every second cycle
    set_rq(0, 3'd0, 16'h0F00);
    set_rq(1, 3'd3, 16'h1F11);
    set_rq(2, 3'd4, 16'h2F22);
    set_rq(3, 3'd7, 16'h3F33);
    push(4'b0001, 3'd0, 16'h0F00);
    push(4'b0010, 3'd3, 16'h1F11);
    push(4'b0100, 3'd4, 16'h2F22);
    push(4'b1000, 3'd7, 16'h3F33);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (!we && n < 8);
      check("rr_spacing", 32'(n), (k == 0) ? 32'd1 : 32'd2);
      req[k] = 1'b0;
    end
    step();

`ifdef REGARB_LOCK_EN
    // Move ptr to 1 so requester 1 wins the burst
    set_rq(0, 3'd1, 16'h0C0C);
    req = 4'b0001;
    push(4'b0001, 3'd1, 16'h0C0C);
    step();
    req = '0;
    step();

    // Lock cap: 8 writes to requester 1, one idle edge, then requester 0
    req  = 4'b0011;
    lock = 4'b0010;
    for (int s = 0; s < 10; s++) begin
      if (s < 8) begin
        set_rq(1, 3'(s), 16'hB000 + 16'(s));
        push(4'b0010, 3'(s), 16'hB000 + 16'(s));
      end
      if (s == 9) push(4'b0001, 3'd1, 16'h0C0C);
      step();
      if (s == 8) begin
        check("cap_end_we",   32'(we),   32'h0);
        check("cap_end_busy", 32'(busy), 32'h0);
      end
    end
    req  = '0;
    lock = '0;
    step();

    // Early unlock after 3 writes; held req then gets a plain write
    req  = 4'b0010;
    lock = 4'b0010;
    set_rq(1, 3'd4, 16'hC001);
    push(4'b0010, 3'd4, 16'hC001);
    step();
    set_rq(1, 3'd5, 16'hC002);
    push(4'b0010, 3'd5, 16'hC002);
    step();
    set_rq(1, 3'd6, 16'hC003);
    push(4'b0010, 3'd6, 16'hC003);
    step();
    check("unlock_busy_hi", 32'(busy), 32'h1);
    lock = '0;
    set_rq(1, 3'd2, 16'hC004);
    push(4'b0010, 3'd2, 16'hC004);
    step();
    check("unlock_we_off",   32'(we),   32'h0);
    check("unlock_busy_off", 32'(busy), 32'h0);
    step();
    req = '0;
    step();
`endif

    repeat (3) step();
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register-file write port.
REQ-002 Parameter DW, default 16: register data width.
REQ-003 Parameter AW, default 3: register address width (8 registers).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  write request, bit i from requester i; held high until that requester sees gnt[i].
REQ-007 lock  input  NREQ  burst-lock request per requester; port present only with REGARB_LOCK_EN.
REQ-008 waddr_in  input  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-009 wdata_in  input  NREQ*DW  packed data, requester i at bits [i*DW +: DW].
REQ-010 gnt  output  NREQ  one-hot grant, registered.
REQ-011 we  output  1  register-file write enable, registered.
REQ-012 waddr  output  AW  register-file write address, registered.
REQ-013 wdata  output  DW  register-file write data, registered.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states: IDLE, WRITE, LOCKED. LOCKED is reachable only with REGARB_LOCK_EN.
REQ-016 Arbitration occurs only at an edge where state is IDLE. It is round-robin from pointer ptr (width clog2(NREQ)): scan ptr, ptr+1, ... mod NREQ; the first i with req[i]=1 wins.
REQ-017 On a win at an edge: gnt=onehot(i), we=1, waddr=waddr_in[i], wdata=wdata_in[i] after that edge; ptr<=(i+1) mod NREQ; state<=WRITE.
REQ-018 WRITE lasts exactly one cycle. At the next edge: state<=IDLE, gnt=0, we=0; waddr and wdata hold their last values.
REQ-019 Latency: req sampled at edge N produces we high from edge N through N+1. Peak throughput without lock is one write per 2 cycles.
REQ-020 At most one gnt bit is high in any cycle. we=1 if and only if gnt is non-zero.
REQ-021 In IDLE with no req bit set: outputs stay deasserted and ptr is unchanged.
REQ-022 A req bit that drops before being sampled is never granted; no request is queued internally.
REQ-023 If NREQ is not a power of two, pointer wrap uses mod NREQ; ptr never holds a value of NREQ or above.

Reset
REQ-024 While rst=0, asynchronously: state=IDLE, ptr=0, gnt=0, we=0, waddr=0, wdata=0, burst counter=0, busy=0.
REQ-025 Reset asserted during WRITE or LOCKED aborts the operation immediately; we falls without waiting for a clock edge.
REQ-026 On the first edge after rst rises, normal arbitration applies with requester 0 at highest priority.

Configuration
REQ-027 Macro REGARB_LOCK_EN. When defined, the lock port exists and the burst behaviour of REQ-028 to REQ-030 applies.
REQ-028 With REGARB_LOCK_EN: if the winner i has lock[i]=1 at the winning edge, the next state is LOCKED instead of WRITE (same outputs), and the 3-bit burst counter is set to 1.
REQ-029 In LOCKED, at each edge:
- If req[i]=1, lock[i]=1 and counter<8: stay LOCKED, issue a new write (gnt[i]=1, we=1, new waddr/wdata), counter++.
- Otherwise: go to IDLE, gnt=0, we=0.
REQ-030 The maximum burst is 8 back-to-back writes; other requesters are ignored during LOCKED; ptr was already advanced at burst start.
REQ-031 Without REGARB_LOCK_EN: no lock port, no counter, the FSM has only IDLE and WRITE, and behaviour is identical to the macro-enabled design with lock tied to 0.

Verification
REQ-032 Reset mid-WRITE: rst=0 while we=1 -> we and gnt go to 0 with no clock edge; after release, req=4'b1111 grants requester 0 first.
REQ-033 Round-robin: req=4'b1111 held, each requester dropping req after its grant -> grant order 0,1,2,3; we pulses every 2nd cycle.
REQ-034 Single request: req[2]=1, waddr_in[2]=3'd5, wdata_in[2]=16'hA5C3 -> one cycle later gnt=4'b0100, we=1, waddr=5, wdata=16'hA5C3; the next cycle we=0, busy=0.
REQ-035 Pointer wrap: grant requester 3, then req=4'b1001 -> requester 0 wins and ptr becomes 1.
REQ-036 Lock cap, REGARB_LOCK_EN: requester 1 holds req and lock for 12 cycles while req[0]=1 -> exactly 8 consecutive we cycles to requester 1, then IDLE, then requester 0 granted.
REQ-037 Early unlock, REGARB_LOCK_EN: lock[1] dropped after 3 writes -> the burst ends after 3 writes and busy falls one edge later.
